// File: rtl/rv32i_instruction_encoder.sv
// Builds RV32I machine words from field-level requests and streams them into
// instruction memory; expands LI into LUI/ADDI and emits the PAUSE hint.
module rv32i_instruction_encoder #(
   parameter int ADDR_WIDTH = 10,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [3:0]            in_kind,
   input  logic [2:0]            in_fn3,
   input  logic [6:0]            in_fn7,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_rs1,
   input  logic [4:0]            in_rs2,
   input  logic [31:0]           in_imm,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic                  mem_ready,
   output logic                  err,
   output logic [ADDR_WIDTH:0]   word_count
);

   localparam logic [3:0] KIND_R     = 4'd0;
   localparam logic [3:0] KIND_I     = 4'd1;
   localparam logic [3:0] KIND_LOAD  = 4'd2;
   localparam logic [3:0] KIND_STORE = 4'd3;
   localparam logic [3:0] KIND_BR    = 4'd4;
   localparam logic [3:0] KIND_LUI   = 4'd5;
   localparam logic [3:0] KIND_AUIPC = 4'd6;
   localparam logic [3:0] KIND_JAL   = 4'd7;
   localparam logic [3:0] KIND_JALR  = 4'd8;
   localparam logic [3:0] KIND_LI    = 4'd9;
   localparam logic [3:0] KIND_PAUSE = 4'd10;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;

   localparam logic [31:0]           PAUSE_WORD = 32'h0100_000F;
   localparam logic [ADDR_WIDTH-1:0] BASE_C     = ADDR_WIDTH'(BASE_ADDR);
   localparam logic [ADDR_WIDTH:0]   COUNT_MAX  = {(ADDR_WIDTH+1){1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_HOLD     = 2'd1,
      ST_HOLD_LUI = 2'd2
   } state_t;

   state_t                state_r;
   logic                  mem_we_r;
   logic [ADDR_WIDTH-1:0] mem_addr_r;
   logic [31:0]           mem_wdata_r;
   logic [31:0]           pend_r;
   logic [ADDR_WIDTH-1:0] offset_r;
   logic [ADDR_WIDTH:0]   word_count_r;
   logic                  err_r;

   logic [31:0] word0_s;
   logic [31:0] word1_s;
   logic        legal_s;
   logic        two_s;
   logic        shift_s;
   logic [19:0] li_hi_s;
   logic        accept_s;
   logic        retire_s;
   logic        load_s;

   function automatic logic fits_simm12(input logic [31:0] v);
      return (v[31:11] == 21'h00_0000) || (v[31:11] == 21'h1F_FFFF);
   endfunction

   function automatic logic fits_branch(input logic [31:0] v);
      return ((v[31:12] == 20'h0_0000) || (v[31:12] == 20'hF_FFFF)) && (v[0] == 1'b0);
   endfunction

   function automatic logic fits_jal(input logic [31:0] v);
      return ((v[31:20] == 12'h000) || (v[31:20] == 12'hFFF)) && (v[0] == 1'b0);
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] fn3, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rs1, fn3, rd, op};
   endfunction

   function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
                                         input logic [6:0] op);
      return {imm, rd, op};
   endfunction

   // (imm + 0x800) >> 12: the +0x800 only carries into bit 12 when imm[11] is set
   assign li_hi_s  = in_imm[31:12] + {19'h0_0000, in_imm[11]};
   assign shift_s  = (in_fn3 == 3'b001) || (in_fn3 == 3'b101);

   assign in_ready = !reset && !flush &&
                     ((state_r == ST_IDLE) || ((state_r == ST_HOLD) && mem_ready));
   assign accept_s = in_valid && in_ready;
   assign retire_s = mem_we_r && mem_ready;
   assign load_s   = accept_s && legal_s;

   // Encode the offered request and judge its legality
   always_comb begin
      word0_s = 32'h0000_0000;
      word1_s = 32'h0000_0000;
      legal_s = 1'b1;
      two_s   = 1'b0;
      case (in_kind)
         KIND_R: word0_s = {in_fn7, in_rs2, in_rs1, in_fn3, in_rd, OP_R};
         KIND_I: begin
            if (shift_s) begin
               word0_s = {in_fn7, in_imm[4:0], in_rs1, in_fn3, in_rd, OP_I};
               legal_s = (in_imm[31:5] == 27'h000_0000) &&
                         ((in_fn7 == 7'h00) || ((in_fn7 == 7'h20) && (in_fn3 == 3'b101)));
            end else begin
               word0_s = enc_i(in_imm[11:0], in_rs1, in_fn3, in_rd, OP_I);
               legal_s = fits_simm12(in_imm);
            end
         end
         KIND_LOAD: begin
            word0_s = enc_i(in_imm[11:0], in_rs1, in_fn3, in_rd, OP_LOAD);
            legal_s = fits_simm12(in_imm);
         end
         KIND_STORE: begin
            word0_s = {in_imm[11:5], in_rs2, in_rs1, in_fn3, in_imm[4:0], OP_STORE};
            legal_s = fits_simm12(in_imm);
         end
         KIND_BR: begin
            word0_s = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_fn3,
                       in_imm[4:1], in_imm[11], OP_BR};
            legal_s = fits_branch(in_imm);
         end
         KIND_LUI: begin
            word0_s = enc_u(in_imm[31:12], in_rd, OP_LUI);
            legal_s = (in_imm[11:0] == 12'h000);
         end
         KIND_AUIPC: begin
            word0_s = enc_u(in_imm[31:12], in_rd, OP_AUIPC);
            legal_s = (in_imm[11:0] == 12'h000);
         end
         KIND_JAL: begin
            word0_s = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OP_JAL};
            legal_s = fits_jal(in_imm);
         end
         KIND_JALR: begin
            word0_s = enc_i(in_imm[11:0], in_rs1, 3'b000, in_rd, OP_JALR);
            legal_s = fits_simm12(in_imm);
         end
         KIND_LI: begin
            if (li_hi_s == 20'h0_0000) begin
               word0_s = enc_i(in_imm[11:0], 5'd0, 3'b000, in_rd, OP_I);
            end else if (in_imm[11:0] == 12'h000) begin
               word0_s = enc_u(li_hi_s, in_rd, OP_LUI);
            end else begin
               word0_s = enc_u(li_hi_s, in_rd, OP_LUI);
               word1_s = enc_i(in_imm[11:0], in_rd, 3'b000, in_rd, OP_I);
               two_s   = 1'b1;
            end
         end
         KIND_PAUSE: word0_s = PAUSE_WORD;
         default: legal_s = 1'b0;
      endcase
   end

   // Write-port FSM, address offset, retire counter and error pulse
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         state_r      <= ST_IDLE;
         mem_we_r     <= 1'b0;
         mem_addr_r   <= BASE_C;
         mem_wdata_r  <= 32'h0000_0000;
         pend_r       <= 32'h0000_0000;
         offset_r     <= {ADDR_WIDTH{1'b0}};
         word_count_r <= {(ADDR_WIDTH+1){1'b0}};
         err_r        <= 1'b0;
      end else begin
         err_r <= accept_s && !legal_s;
         if (retire_s) begin
            offset_r   <= offset_r + ADDR_WIDTH'(1);
            mem_addr_r <= BASE_C + offset_r + ADDR_WIDTH'(1);
            if (word_count_r != COUNT_MAX) begin
               word_count_r <= word_count_r + (ADDR_WIDTH+1)'(1);
            end else begin
               word_count_r <= word_count_r;
            end
         end else begin
            offset_r   <= offset_r;
            mem_addr_r <= mem_addr_r;
         end
         case (state_r)
            ST_IDLE, ST_HOLD: begin
               if (load_s) begin
                  mem_we_r    <= 1'b1;
                  mem_wdata_r <= word0_s;
                  pend_r      <= word1_s;
                  state_r     <= two_s ? ST_HOLD_LUI : ST_HOLD;
               end else if (retire_s) begin
                  mem_we_r <= 1'b0;
                  state_r  <= ST_IDLE;
               end else begin
                  state_r <= state_r;
               end
            end
            ST_HOLD_LUI: begin
               if (retire_s) begin
                  mem_wdata_r <= pend_r;
                  state_r     <= ST_HOLD;
               end else begin
                  state_r <= ST_HOLD_LUI;
               end
            end
            default: begin
               mem_we_r <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

   assign mem_we     = mem_we_r;
   assign mem_addr   = mem_addr_r;
   assign mem_wdata  = mem_wdata_r;
   assign err        = err_r;
   assign word_count = word_count_r;

endmodule

// File: tb/tb_rv32i_instruction_encoder.sv
// Directed bench for rv32i_instruction_encoder: a word-queue model of the write
// stream is compared against the DUT every cycle, plus literal expectations.
module tb_rv32i_instruction_encoder;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset, flush, in_valid, in_ready, mem_we, mem_ready, err;
   logic [3:0]    in_kind;
   logic [2:0]    in_fn3;
   logic [6:0]    in_fn7;
   logic [4:0]    in_rd, in_rs1, in_rs2;
   logic [31:0]   in_imm, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic [AW:0]   word_count;

   always #5 clk = ~clk;

   rv32i_instruction_encoder #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_kind(in_kind), .in_fn3(in_fn3), .in_fn7(in_fn7), .in_rd(in_rd), .in_rs1(in_rs1),
      .in_rs2(in_rs2), .in_imm(in_imm), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .err(err), .word_count(word_count)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] q[$];
   logic [31:0] log_d[$];
   int          log_a[$];
   int          off_m = 0;
   int          cnt_m = 0;
   bit          err_m = 1'b0;
   bit          started = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference encoder: the RV32I field layouts written as shifted arithmetic
   function automatic void model_enc(input logic [3:0] k, input logic [2:0] f3, input logic [6:0] f7,
                                     input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [31:0] imm, output bit ok, output int n,
                                     output logic [31:0] w0, output logic [31:0] w1);
      int          s;
      logic [31:0] RD, RS1, RS2, F3, F7, hi, lo;
      s = $signed(imm);
      RD = 32'(rd); RS1 = 32'(rs1); RS2 = 32'(rs2); F3 = 32'(f3); F7 = 32'(f7);
      ok = 1'b1; n = 1; w0 = 32'h0; w1 = 32'h0;
      case (k)
         4'd0: w0 = (F7 << 25) | (RS2 << 20) | (RS1 << 15) | (F3 << 12) | (RD << 7) | 32'h33;
         4'd1: begin
            if (f3 == 3'd1 || f3 == 3'd5) begin
               ok = (s >= 0) && (s <= 31) && (f7 == 7'h00 || (f7 == 7'h20 && f3 == 3'd5));
               w0 = (F7 << 25) | (imm << 20) | (RS1 << 15) | (F3 << 12) | (RD << 7) | 32'h13;
            end else begin
               ok = (s >= -2048) && (s <= 2047);
               w0 = ((imm & 32'hFFF) << 20) | (RS1 << 15) | (F3 << 12) | (RD << 7) | 32'h13;
            end
         end
         4'd2: begin
            ok = (s >= -2048) && (s <= 2047);
            w0 = ((imm & 32'hFFF) << 20) | (RS1 << 15) | (F3 << 12) | (RD << 7) | 32'h03;
         end
         4'd3: begin
            ok = (s >= -2048) && (s <= 2047);
            w0 = (((imm >> 5) & 32'h7F) << 25) | (RS2 << 20) | (RS1 << 15) | (F3 << 12) |
                 ((imm & 32'h1F) << 7) | 32'h23;
         end
         4'd4: begin
            ok = (s >= -4096) && (s <= 4094) && (imm[0] == 1'b0);
            w0 = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (RS2 << 20) |
                 (RS1 << 15) | (F3 << 12) | (((imm >> 1) & 32'hF) << 8) |
                 (((imm >> 11) & 32'h1) << 7) | 32'h63;
         end
         4'd5, 4'd6: begin
            ok = (imm & 32'hFFF) == 32'h0;
            w0 = (imm & 32'hFFFF_F000) | (RD << 7) | ((k == 4'd5) ? 32'h37 : 32'h17);
         end
         4'd7: begin
            ok = (s >= -1048576) && (s <= 1048574) && (imm[0] == 1'b0);
            w0 = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
                 (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (RD << 7) | 32'h6F;
         end
         4'd8: begin
            ok = (s >= -2048) && (s <= 2047);
            w0 = ((imm & 32'hFFF) << 20) | (RS1 << 15) | (RD << 7) | 32'h67;
         end
         4'd9: begin
            hi = (imm + 32'h800) >> 12;
            lo = imm & 32'hFFF;
            if (hi == 32'h0) begin
               w0 = (lo << 20) | (RD << 7) | 32'h13;
            end else if (lo == 32'h0) begin
               w0 = (hi << 12) | (RD << 7) | 32'h37;
            end else begin
               n  = 2;
               w0 = (hi << 12) | (RD << 7) | 32'h37;
               w1 = (lo << 20) | (RD << 15) | (RD << 7) | 32'h13;
            end
         end
         4'd10: w0 = 32'h0100_000F;
         default: ok = 1'b0;
      endcase
   endfunction

   // Compare the DUT against the model, then advance the model to the next edge
   always @(negedge clk) begin : monitor
      bit          rdy_m, ok;
      int          n;
      logic [31:0] w0, w1;
      if (started) begin
         rdy_m = !reset && !flush && (q.size() == 0 || (q.size() == 1 && mem_ready));
         chk("in_ready", 64'(in_ready), 64'(rdy_m));
         chk("mem_we", 64'(mem_we), 64'(q.size() > 0));
         if (q.size() > 0) begin
            chk("mem_addr", 64'(mem_addr), 64'(off_m));
            chk("mem_wdata", 64'(mem_wdata), 64'(q[0]));
         end
         chk("err", 64'(err), 64'(err_m));
         chk("word_count", 64'(word_count), 64'(cnt_m));
      end
      if (reset || flush) begin
         q.delete();
         off_m = 0; cnt_m = 0; err_m = 1'b0;
         if (reset) started = 1'b1;
      end else begin
         rdy_m = (q.size() == 0) || (q.size() == 1 && mem_ready);
         err_m = 1'b0;
         ok    = 1'b0;
         n     = 0;
         if (in_valid && rdy_m)
            model_enc(in_kind, in_fn3, in_fn7, in_rd, in_rs1, in_rs2, in_imm, ok, n, w0, w1);
         if (q.size() > 0 && mem_ready) begin
            if (log_d.size() < 18) begin
               log_a.push_back(off_m);
               log_d.push_back(q[0]);
            end
            void'(q.pop_front());
            off_m = (off_m + 1) % (1 << AW);
            if (cnt_m < (1 << (AW + 1)) - 1) cnt_m++;
         end
         if (in_valid && rdy_m) begin
            if (ok) begin
               q.push_back(w0);
               if (n == 2) q.push_back(w1);
            end else begin
               err_m = 1'b1;
            end
         end
      end
   end

   // Offer one request starting at posedge+1, hold it until accepted
   task automatic send(input logic [3:0] k, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
      int t;
      in_kind = k; in_fn3 = f3; in_fn7 = f7; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
      in_valid = 1'b1;
      for (t = 0; t < 64; t++) begin
         @(negedge clk);
         if (in_ready) break;
      end
      if (t == 64) begin
         n_cmp++; n_bad++;
         $display("FAIL accept_timeout: in_ready stayed 0 for kind %0d, want 1", k);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pin(input string name, input logic [3:0] k, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [31:0] imm, input bit ok_e, input int n_e,
                      input logic [31:0] w0_e, input logic [31:0] w1_e);
      bit ok; int n; logic [31:0] w0, w1;
      model_enc(k, f3, f7, rd, rs1, rs2, imm, ok, n, w0, w1);
      chk({name, "_ok"}, 64'(ok), 64'(ok_e));
      if (ok_e) begin
         chk({name, "_n"}, 64'(n), 64'(n_e));
         chk({name, "_w0"}, 64'(w0), 64'(w0_e));
         if (n_e == 2) chk({name, "_w1"}, 64'(w1), 64'(w1_e));
      end
   endtask

   logic [31:0] exp_d [18] = '{32'h00500093, 32'h0021A423, 32'hFE208EE3, 32'h123462B7,
                               32'hFFF28293, 32'h0100000F, 32'h00001337, 32'h80030313,
                               32'h402081B3, 32'h4032D213, 32'h001000EF, 32'h00008067,
                               32'hFFC42383, 32'hABCDE4B7, 32'h00001517, 32'h80008093,
                               32'h00500093, 32'h00500093};
   int          exp_a [18] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 0, 0};

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1);
   end

   initial begin
      reset = 1'b1; flush = 1'b0; in_valid = 1'b0; mem_ready = 1'b1;
      in_kind = 4'd0; in_fn3 = 3'd0; in_fn7 = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0;
      in_imm = 32'h0;

      pin("m_addi",  4'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5,        1'b1, 1, 32'h00500093, 32'h0);
      pin("m_sw",    4'd3, 3'd2, 7'd0, 5'd0, 5'd3, 5'd2, 32'd8,        1'b1, 1, 32'h0021A423, 32'h0);
      pin("m_beq",   4'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b1, 1, 32'hFE208EE3, 32'h0);
      pin("m_li5",   4'd9, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF, 1'b1, 2, 32'h123462B7, 32'hFFF28293);
      pin("m_pause", 4'd10, 3'd7, 7'h7F, 5'd9, 5'd9, 5'd9, 32'hFFFFFFFF, 1'b1, 1, 32'h0100000F, 32'h0);
      pin("m_li6",   4'd9, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 32'h00000800, 1'b1, 2, 32'h00001337, 32'h80030313);
      pin("m_addi_big", 4'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 1, 32'h0, 32'h0);
      pin("m_beq_odd",  4'd4, 3'd0, 7'd0, 5'd1, 5'd1, 5'd2, 32'd3,    1'b0, 1, 32'h0, 32'h0);
      pin("m_kind12",   4'd12, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0,   1'b0, 1, 32'h0, 32'h0);

      step(2);
      chk("rst_mem_we", 64'(mem_we), 64'd0);
      chk("rst_mem_addr", 64'(mem_addr), 64'd0);
      chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk("rst_word_count", 64'(word_count), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", 64'(in_ready), 64'd1);
      step(1);

      send(4'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
      chk("addi_we", 64'(mem_we), 64'd1);
      chk("addi_data", 64'(mem_wdata), 64'h00500093);
      step(1);
      chk("addi_count", 64'(word_count), 64'd1);
      flush = 1'b1; step(1); flush = 1'b0;

      send(4'd3, 3'd2, 7'd0, 5'd0, 5'd3, 5'd2, 32'd8);
      send(4'd4, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC);
      step(1);
      mem_ready = 1'b0;
      send(4'd9, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
      step(3);
      chk("li_stall_data", 64'(mem_wdata), 64'h123462B7);
      mem_ready = 1'b1;
      step(2);
      send(4'd10, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h0);
      send(4'd9, 3'd0, 7'd0, 5'd6, 5'd0, 5'd0, 32'h00000800);
      send(4'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
      send(4'd4, 3'd0, 7'd0, 5'd1, 5'd1, 5'd2, 32'd3);
      send(4'd12, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      step(2);

      send(4'd0, 3'd0, 7'h20, 5'd3, 5'd1, 5'd2, 32'd0);
      send(4'd1, 3'd5, 7'h20, 5'd4, 5'd5, 5'd0, 32'd3);
      send(4'd7, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd2048);
      send(4'd8, 3'd7, 7'd0, 5'd0, 5'd1, 5'd0, 32'd0);
      send(4'd2, 3'd2, 7'd0, 5'd7, 5'd8, 5'd0, 32'hFFFFFFFC);
      send(4'd5, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'hABCDE000);
      send(4'd6, 3'd0, 7'd0, 5'd10, 5'd0, 5'd0, 32'h00001000);
      send(4'd1, 3'd0, 7'd0, 5'd1, 5'd1, 5'd0, 32'hFFFFF800);
      send(4'd1, 3'd1, 7'h20, 5'd1, 5'd1, 5'd0, 32'd3);
      send(4'd1, 3'd5, 7'd0, 5'd1, 5'd1, 5'd0, 32'd32);
      send(4'd7, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd3);
      send(4'd5, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h00000123);
      send(4'd15, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      send(4'd3, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'hFFFFF7FF);
      step(2);
      chk("count_after_errors", 64'(word_count), 64'd15);

      mem_ready = 1'b0;
      send(4'd9, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
      flush = 1'b1; mem_ready = 1'b1;
      step(1);
      flush = 1'b0;
      chk("flush_we", 64'(mem_we), 64'd0);
      chk("flush_count", 64'(word_count), 64'd0);
      send(4'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
      step(1);

      mem_ready = 1'b0;
      send(4'd9, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345FFF);
      reset = 1'b1; step(1); reset = 1'b0; mem_ready = 1'b1;
      send(4'd1, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd5);
      step(1);

      for (int i = 0; i < 18; i++) begin
         if (i < log_d.size()) begin
            chk($sformatf("log_addr%0d", i), 64'(log_a[i]), 64'(exp_a[i]));
            chk($sformatf("log_data%0d", i), 64'(log_d[i]), 64'(exp_d[i]));
         end else begin
            n_cmp++; n_bad++;
            $display("FAIL log_missing: entry %0d absent, want %h", i, exp_d[i]);
         end
      end

      for (int i = 0; i < 2100; i++) send(4'd1, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      step(2);
      chk("count_saturated", 64'(word_count), 64'd2047);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
